btn_conditioner: RTL and testbench

Conditions a raw, bouncy push-button into clean single-cycle events for the LED sequencer stages. Sits directly upstream of the LED chaser: its pulses drive the chaser's restart/mode inputs in the board-level top, on the same raw board clock as the 1 Hz divider. Provides synchronisation, debounce, press/release edges, long-press detection and optional auto-repeat.

---
 rtl/btn_conditioner_if.sv | 26 ++
 rtl/btn_conditioner.sv | 135 +++++++++++++
 tb/tb_btn_conditioner.sv | 113 +++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: button conditioner signal bundle.
//   btn_i      raw button, active-high, asynchronous to the board clock
//   btn_level  debounced level
//   press_p    one-cycle pulse on accepted press
//   release_p  one-cycle pulse on accepted release
//   long_p     one-cycle pulse when the long-press threshold is reached
//   held_long  high from long_p until release
//   repeat_p   one-cycle auto-repeat pulse
// master: the button/consumer side; slave: the conditioner.
interface btn_conditioner_if;
    logic btn_i;
    logic btn_level;
    logic press_p;
    logic release_p;
    logic long_p;
    logic held_long;
    logic repeat_p;
    modport master (
        output btn_i,
        input  btn_level, press_p, release_p, long_p, held_long, repeat_p
    );
    modport slave (
        input  btn_i,
        output btn_level, press_p, release_p, long_p, held_long, repeat_p
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and classify a raw push-button into clean one-cycle events.
//   clki  board clock, all state on rising edge
//   rs    asynchronous active-low reset
//   bus   btn_conditioner_if.slave (btn_i in; btn_level, press_p, release_p, long_p, held_long, repeat_p out)
// Optional feature: define BTN_REPEAT_EN to compile in auto-repeat; otherwise repeat_p is held at 0.
module btn_conditioner #(
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int REP_CYCLES  = 10000000
) (
    input logic              clki,
    input logic              rs,
    btn_conditioner_if.slave bus
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    if (DB_CYCLES < 2 || LONG_CYCLES < 2 || REP_CYCLES < 2) begin : g_bad_params
        $error("btn_conditioner: cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t        state, state_n;
    logic          s1, s2, level;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          toggle, rise, fall;
    logic          press_n, release_n, long_n, held_n, rep_n;

    // The FSM reacts to the debounce toggle itself, so its registered pulses
    // appear on the same edge as the new btn_level.
    assign toggle = (s2 != level) && (db_cnt == DW'(DB_CYCLES - 1));
    assign rise   = toggle && !level;
    assign fall   = toggle && level;
    assign bus.btn_level = level;

    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1     <= bus.btn_i;
            s2     <= s1;
            level  <= level ^ toggle;
            db_cnt <= (s2 == level || toggle) ? '0 : db_cnt + DW'(1);
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REP_CYCLES + 1);
    logic [RW-1:0] rep_cnt, rep_cnt_n;
`endif

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        rep_n     = 1'b0;
`ifdef BTN_REPEAT_EN
        rep_cnt_n = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    press_n = 1'b1;
                    hold_n  = '0;
                    state_n = PRESSED;
                end
            end
            PRESSED: begin
                // release has priority over a coincident long-press threshold
                if (fall) begin
                    release_n = 1'b1;
                    state_n   = IDLE;
                end else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                    long_n  = 1'b1;
                    state_n = LONG;
`ifdef BTN_REPEAT_EN
                    rep_cnt_n = '0;
`endif
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    release_n = 1'b1;
                    state_n   = IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (rep_cnt == RW'(REP_CYCLES - 1)) begin
                    rep_n     = 1'b1;
                    rep_cnt_n = '0;
                end else begin
                    rep_cnt_n = rep_cnt + RW'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        held_n = (state_n == LONG);
    end

    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            bus.press_p   <= 1'b0;
            bus.release_p <= 1'b0;
            bus.long_p    <= 1'b0;
            bus.held_long <= 1'b0;
            bus.repeat_p  <= 1'b0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_n;
            bus.press_p   <= press_n;
            bus.release_p <= release_n;
            bus.long_p    <= long_n;
            bus.held_long <= held_n;
            bus.repeat_p  <= rep_n;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) rep_cnt <= '0;
        else     rep_cnt <= rep_cnt_n;
    end
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed self-checking bench for btn_conditioner (DB=4, LONG=20, REP=5).
module tb_btn_conditioner;
    logic clk = 1'b0;
    logic rs  = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    btn_conditioner_if bus();

    btn_conditioner #(.DB_CYCLES(4), .LONG_CYCLES(20), .REP_CYCLES(5)) dut (
        .clki (clk),
        .rs   (rs),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // {btn_level, press_p, release_p, long_p, held_long, repeat_p}
    logic [5:0] outs;
    assign outs = {bus.btn_level, bus.press_p, bus.release_p, bus.long_p, bus.held_long, bus.repeat_p};

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] PR   = 6'b110000;
    localparam logic [5:0] HD   = 6'b100000;
    localparam logic [5:0] REL  = 6'b001000;
    localparam logic [5:0] LG   = 6'b100110;
    localparam logic [5:0] HL   = 6'b100010;
`ifdef BTN_REPEAT_EN
    localparam logic [5:0] RP   = 6'b100011;
`else
    localparam logic [5:0] RP   = 6'b100010;
`endif

    task automatic chk(input string tag, input logic [5:0] exp);
        n_chk++;
        assert (outs === exp) else begin
            n_fail++;
            $error("FAIL %s: outputs %b expected %b", tag, outs, exp);
        end
    endtask

    // advance n clock edges, checking the outputs 1 time unit after each edge
    task automatic steps(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk(tag, exp);
        end
    endtask

    initial begin
        bus.btn_i = 1'b1;
        steps("reset_held", 2, NONE);
        rs = 1'b1;
        steps("post_reset_debounce", 5, NONE);
        steps("post_reset_press", 1, PR);
        steps("short_hold", 10, HD);
        bus.btn_i = 1'b0;
        steps("release_debounce", 5, HD);
        steps("short_release", 1, REL);
        steps("idle_after_short", 3, NONE);

        for (int r = 0; r < 5; r++) begin
            bus.btn_i = 1'b1;
            steps("bounce_high", 3, NONE);
            bus.btn_i = 1'b0;
            steps("bounce_low", 1, NONE);
        end
        bus.btn_i = 1'b1;
        steps("steady_debounce", 5, NONE);
        steps("steady_press", 1, PR);

        steps("long_hold", 19, HD);
        steps("long_fire", 1, LG);
        steps("long_wait1", 4, HL);
        steps("repeat1", 1, RP);
        steps("long_wait2", 4, HL);
        steps("repeat2", 1, RP);
        steps("long_wait3", 4, HL);
        bus.btn_i = 1'b0;
        steps("repeat3", 1, RP);
        steps("long_release_debounce", 4, HL);
        steps("long_release_vs_repeat", 1, REL);
        steps("idle_after_long", 3, NONE);

        bus.btn_i = 1'b1;
        steps("race_debounce", 5, NONE);
        steps("race_press", 1, PR);
        steps("race_hold", 14, HD);
        bus.btn_i = 1'b0;
        steps("race_release_debounce", 5, HD);
        steps("race_release_vs_long", 1, REL);
        steps("idle_after_race", 3, NONE);

        bus.btn_i = 1'b1;
        steps("mid_debounce", 5, NONE);
        steps("mid_press", 1, PR);
        steps("mid_hold", 19, HD);
        steps("mid_long", 1, LG);
        steps("mid_held", 2, HL);
        #3 rs = 1'b0;
        #1 chk("async_reset_immediate", NONE);
        steps("reset_low_held", 2, NONE);
        rs = 1'b1;
        steps("rearm_debounce", 5, NONE);
        steps("rearm_press", 1, PR);
        steps("rearm_pressed", 19, HD);
        steps("rearm_long", 1, LG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
